// File: rtl/mem_loader_if.sv
// ---------------------------------------------------------------------------
// mem_loader_if
// Bundles the byte load stream, the 256x16 RAM port and the status lines
// used by mem_loader.
//   byte_valid / byte_data / byte_ready : load-stream handshake
//   mem_we / mem_addr / mem_d / mem_q    : RAM port (mem_q combinational)
//   cpu_rst / done / error               : CPU reset hold and load status
// modport master : the loader side (drives RAM port, ready and status)
// modport slave  : the environment side (stream source and RAM)
// ---------------------------------------------------------------------------
interface mem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_d;
    logic [15:0] mem_q;
    logic        cpu_rst;
    logic        done;
    logic        error;

    modport master (
        input  byte_valid, byte_data, mem_q,
        output byte_ready, mem_we, mem_addr, mem_d, cpu_rst, done, error
    );

    modport slave (
        output byte_valid, byte_data, mem_q,
        input  byte_ready, mem_we, mem_addr, mem_d, cpu_rst, done, error
    );
endinterface

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Loads a 256x16 RAM from a byte stream: ADDR, CNT (0 = 256 words), then
// CNT words sent high byte first. Each word is written the cycle after its
// low byte arrives. With VERIFY_EN=1 the written range is read back and its
// checksum compared with the checksum of the written words. The CPU is held
// in reset until the load finishes cleanly.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_loader_if.master (stream handshake, RAM port, status)
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    mem_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_ADDR, S_CNT, S_HI, S_LO, S_WR, S_VFY, S_CHK, S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [7:0]  start_addr;
    logic [7:0]  hi_byte;
    logic [15:0] word;
    logic [15:0] sum;
    logic [15:0] vsum;
    logic [8:0]  remaining;
    logic [8:0]  count;
    logic        error_q;
    logic        xfer;

    assign xfer = bus.byte_valid && bus.byte_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ADDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Stream states only advance on a transfer, so the
    // block simply waits while byte_valid is low.
    always_comb begin
        state_next = state;
        case (state)
            S_ADDR: if (xfer) state_next = S_CNT;
            S_CNT:  if (xfer) state_next = S_HI;
            S_HI:   if (xfer) state_next = S_LO;
            S_LO:   if (xfer) state_next = S_WR;
            S_WR: begin
                if (remaining == 9'd1) begin
                    state_next = VERIFY_EN ? S_VFY : S_DONE;
                end else begin
                    state_next = S_HI;
                end
            end
            S_VFY:  if (remaining == 9'd1) state_next = S_CHK;
            S_CHK:  state_next = S_DONE;
            S_DONE: state_next = S_DONE;
            default: state_next = S_ADDR;
        endcase
    end

    // Datapath registers. The remaining counter is reloaded with the
    // original word count on entry to S_VFY and reused as the read-back
    // cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 8'h00;
            rd_ptr     <= 8'h00;
            start_addr <= 8'h00;
            hi_byte    <= 8'h00;
            word       <= 16'h0000;
            sum        <= 16'h0000;
            vsum       <= 16'h0000;
            remaining  <= 9'd0;
            count      <= 9'd0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (xfer) begin
                        wr_ptr     <= bus.byte_data;
                        start_addr <= bus.byte_data;
                    end
                end
                S_CNT: begin
                    if (xfer) begin
                        remaining <= (bus.byte_data == 8'h00) ? 9'd256 : {1'b0, bus.byte_data};
                        count     <= (bus.byte_data == 8'h00) ? 9'd256 : {1'b0, bus.byte_data};
                    end
                end
                S_HI: begin
                    if (xfer) hi_byte <= bus.byte_data;
                end
                S_LO: begin
                    if (xfer) word <= {hi_byte, bus.byte_data};
                end
                S_WR: begin
                    sum       <= sum + word;
                    wr_ptr    <= wr_ptr + 8'd1;
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1 && VERIFY_EN) begin
                        rd_ptr    <= start_addr;
                        vsum      <= 16'h0000;
                        remaining <= count;
                    end
                end
                S_VFY: begin
                    vsum      <= vsum + bus.mem_q;
                    rd_ptr    <= rd_ptr + 8'd1;
                    remaining <= remaining - 9'd1;
                end
                S_CHK: begin
                    error_q <= (vsum != sum);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from the state. While rst is high every output is
    // forced to its idle value, even before the reset edge lands.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 8'h00;
        bus.mem_d      = 16'h0000;
        bus.cpu_rst    = 1'b1;
        bus.done       = 1'b0;
        bus.error      = 1'b0;
        if (!rst) begin
            bus.error = error_q;
            case (state)
                S_ADDR, S_CNT, S_HI, S_LO: bus.byte_ready = 1'b1;
                S_WR: begin
                    bus.mem_we   = 1'b1;
                    bus.mem_addr = wr_ptr;
                    bus.mem_d    = word;
                end
                S_VFY: bus.mem_addr = rd_ptr;
                S_DONE: begin
                    bus.done    = 1'b1;
                    bus.cpu_rst = error_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter VERIFY_EN, default 1; when 1, the block performs a checksum read-back pass after writing.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port byte_valid, input, 1 bit: the load-stream byte is present.
REQ-005 The block SHALL have port byte_data, input, 8 bits: the load-stream byte.
REQ-006 The block SHALL have port byte_ready, output, 1 bit: the block accepts the byte; a transfer occurs when byte_valid and byte_ready are both 1 at a rising edge.
REQ-007 The block SHALL have port mem_we, output, 1 bit: the write enable to the 256x16 RAM.
REQ-008 The block SHALL have port mem_addr, output, 8 bits: the RAM address.
REQ-009 The block SHALL have port mem_d, output, 16 bits: the RAM write data.
REQ-010 The block SHALL have port mem_q, input, 16 bits: the RAM read data, combinational from mem_addr and valid in the same cycle.
REQ-011 The block SHALL have port cpu_rst, output, 1 bit: the CPU reset hold.
REQ-012 The block SHALL have port done, output, 1 bit: the load is complete.
REQ-013 The block SHALL have port error, output, 1 bit: the verify checksum mismatched.

Function
REQ-014 The block SHALL accept the stream format ADDR byte (start address), CNT byte (word count, 0 means 256), then CNT words, each sent high byte first, then low byte.
REQ-015 The block SHALL implement the states S_ADDR, S_CNT, S_HI, S_LO, S_WR, S_VFY, S_CHK and S_DONE.
REQ-016 The block SHALL drive byte_ready=1 only in S_ADDR, S_CNT, S_HI and S_LO, and 0 in all other states.
REQ-017 The block SHALL hold its state while byte_valid=0, with no timeout.
REQ-018 On a transfer in S_ADDR, the block SHALL load the write pointer and the start register with byte_data and go to S_CNT.
REQ-019 On a transfer in S_CNT, the block SHALL load remaining with byte_data, or with 256 if byte_data is 0 (9-bit counter), and go to S_HI.
REQ-020 On a transfer in S_HI, the block SHALL latch the high byte and go to S_LO.
REQ-021 On a transfer in S_LO, the block SHALL form the word {hi, byte_data} and go to S_WR.
REQ-022 In S_WR, the block SHALL drive mem_we=1 for exactly one cycle, with mem_addr = write pointer and mem_d = word.
REQ-023 In S_WR, the block SHALL add the word to sum (16-bit, modulo 2^16), increment the write pointer (modulo 256, so 0xFF wraps to 0x00), and decrement remaining.
REQ-024 When S_WR is entered with remaining=1, the block SHALL go next to S_VFY if VERIFY_EN=1, or to S_DONE if VERIFY_EN=0; otherwise it SHALL go to S_HI.
REQ-025 The block SHALL write each word in the cycle immediately after its low byte is accepted.
REQ-026 The block SHALL drive mem_we=0 in every state other than S_WR.
REQ-027 On entry to S_VFY, the block SHALL set the read pointer to the start register and vsum to 0.
REQ-028 In S_VFY, the block SHALL spend one cycle per word: mem_addr = read pointer, vsum += mem_q (modulo 2^16), read pointer +1 (wrapping), for the original count of cycles, then go to S_CHK.
REQ-029 In S_CHK, which lasts one cycle, the block SHALL set error = (vsum != sum) and go to S_DONE.
REQ-030 In S_DONE, the block SHALL set done=1 and remain in S_DONE until rst; further bytes are not accepted (byte_ready=0).
REQ-031 The block SHALL drive cpu_rst=1 in every state except S_DONE; in S_DONE, cpu_rst SHALL equal error, so the CPU stays held after a failed verify.
REQ-032 When byte_valid is held at 1, a load of N words SHALL take 2 + 3N cycles to the last write, plus N+1 cycles if VERIFY_EN=1, and SHALL then enter S_DONE.

Reset
REQ-033 When rst=1 at a rising edge, the block SHALL enter S_ADDR in any state, including mid-load.
REQ-034 When rst=1 at a rising edge, the block SHALL clear sum, vsum, remaining, the pointers, done and error.
REQ-035 When rst=1 at a rising edge, the block SHALL set mem_we=0, mem_addr=0x00, mem_d=0x0000, cpu_rst=1 and byte_ready=0 during rst.
REQ-036 After reset, byte_ready SHALL be 1 in the first cycle following rst deasserting.
REQ-037 RAM words already written before a mid-load reset SHALL remain unchanged; the block does not roll them back.

Verification
REQ-038 The bench SHALL cover a basic load: stream 0x0C,0x02,0x12,0x34,0xAB,0xCD with byte_valid held at 1 -> writes RAM[0x0C]=0x1234 and RAM[0x0D]=0xABCD, each mem_we pulse 1 cycle wide, then done=1, error=0, cpu_rst=0.
REQ-039 The bench SHALL cover address wrap: ADDR=0xFF, CNT=0x02, words 0x0001,0x0002 -> RAM[0xFF]=0x0001, RAM[0x00]=0x0002; sum=0x0003; error=0.
REQ-040 The bench SHALL cover count zero: CNT=0x00 with 256 words of 0x0100 -> all 256 locations written, sum wraps to 0x0000, done asserted 2+768+257 cycles after the first transfer.
REQ-041 The bench SHALL cover a verify failure: a bench RAM model corrupts RAM[0x05] after the write -> error=1, done=1, cpu_rst stays 1.
REQ-042 The bench SHALL cover backpressure and reset: byte_valid toggles 0/1 randomly, then rst=1 after the first word -> state returns to S_ADDR, cpu_rst=1, the first word stays in RAM, and a new load then completes correctly.
